mor1kx_icache_refill_master: RTL and testbench



---
 rtl/mor1kx_icache_refill_master_pkg.sv | 21 ++
 rtl/mor1kx_icache_refill_master.sv | 121 ++++++++++++
 tb/tb_mor1kx_icache_refill_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_icache_refill_master_pkg.sv
// Shared definitions for the cache refill engines: one-hot state encoding
// and the block-size derivations used by the burst beat counter.
package mor1kx_icache_refill_master_pkg;

    typedef enum logic [2:0] {
        RM_IDLE    = 3'b001,
        RM_BURST   = 3'b010,
        RM_ERRWAIT = 3'b100
    } rm_state_t;

    // Width of the beat counter for a block of 2^block_width bytes.
    function automatic int rm_cnt_width(input int block_width);
        return block_width - 2;
    endfunction

    // Number of 32-bit words in one cache block.
    function automatic int rm_nwords(input int block_width);
        return 1 << (block_width - 2);
    endfunction

endpackage

// File: rtl/mor1kx_icache_refill_master.sv
// Instruction-cache refill engine. On a refill request it runs one
// critical-word-first wrapping burst over the instruction bus and streams
// every returned word straight into the cache. A bus error aborts the burst,
// pulses imem_err_o, and parks the engine until the cache drops its request.
module mor1kx_icache_refill_master
    import mor1kx_icache_refill_master_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    output logic                            ibus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
    output logic                            ibus_burst_o,
    input  logic                            ibus_ack_i,
    input  logic                            ibus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            imem_err_o,
    output logic                            busy_o
);

    localparam int W     = OPTION_OPERAND_WIDTH;
    localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int CNT_W = rm_cnt_width(BW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(rm_nwords(BW) - 1);

    rm_state_t        state_r;
    logic [W-1:0]     adr_r;
    logic [CNT_W-1:0] count_r;
    logic             req_r;

    logic             in_burst_s;
    logic             beat_ok_s;
    logic             beat_err_s;
    logic             unused_s;

    // Advance to the next word of the block, wrapping inside the block so
    // the tag/index bits above the block offset never change.
    function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] a);
        logic [CNT_W-1:0] word_s;
        word_s   = a[BW-1:2] + CNT_W'(1);
        wrap_inc = {a[W-1:BW], word_s, 2'b00};
    endfunction

    // Byte-offset bits of the miss address are irrelevant for word fetches.
    assign unused_s   = ^refill_adr_i[1:0];

    assign in_burst_s = (state_r == RM_BURST);
    // Error has priority over ack: an errored beat never reaches the cache.
    assign beat_err_s = in_burst_s & ibus_err_i;
    assign beat_ok_s  = in_burst_s & ibus_ack_i & ~ibus_err_i;

    // Refill sequencing: latch the critical word, walk the block, abort on error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RM_IDLE;
            adr_r   <= {W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            req_r   <= 1'b0;
        end else begin
            case (state_r)
                RM_IDLE: begin
                    if (refill_req_i) begin
                        adr_r   <= {refill_adr_i[W-1:2], 2'b00};
                        count_r <= {CNT_W{1'b0}};
                        req_r   <= 1'b1;
                        state_r <= RM_BURST;
                    end else begin
                        req_r   <= 1'b0;
                    end
                end
                RM_BURST: begin
                    if (ibus_err_i) begin
                        req_r   <= 1'b0;
                        state_r <= RM_ERRWAIT;
                    end else if (ibus_ack_i) begin
                        adr_r   <= wrap_inc(adr_r);
                        count_r <= count_r + CNT_W'(1);
                        if (count_r == LAST_CNT) begin
                            req_r   <= 1'b0;
                            state_r <= RM_IDLE;
                        end else begin
                            req_r   <= 1'b1;
                        end
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                RM_ERRWAIT: begin
                    req_r <= 1'b0;
                    // Wait for the cache to withdraw the stale request.
                    if (!refill_req_i) begin
                        state_r <= RM_IDLE;
                    end else begin
                        state_r <= RM_ERRWAIT;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= RM_IDLE;
                end
            endcase
        end
    end

    assign ibus_req_o   = req_r;
    assign ibus_adr_o   = adr_r;
    assign ibus_burst_o = in_burst_s & (count_r != LAST_CNT);
    assign wradr_o      = adr_r;
    assign wrdat_o      = ibus_dat_i;
    assign we_o         = beat_ok_s;
    assign imem_err_o   = beat_err_s;
    assign busy_o       = (state_r != RM_IDLE);

endmodule

// File: tb/tb_mor1kx_icache_refill_master.sv
// Directed bench for the icache refill engine: one 32-byte-block instance
// and one 16-byte-block instance, driven by a linear sequence of steps.
module tb_mor1kx_icache_refill_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 32-byte block instance
    logic        refill_req5 = 1'b0;
    logic [31:0] refill_adr5 = 32'h0;
    logic        ack5 = 1'b0, err5 = 1'b0;
    logic [31:0] dat5 = 32'h0;
    logic        req5, burst5, we5, ierr5, busy5;
    logic [31:0] adr5, wradr5, wrdat5;

    // 16-byte block instance
    logic        refill_req4 = 1'b0;
    logic [31:0] refill_adr4 = 32'h0;
    logic        ack4 = 1'b0, err4 = 1'b0;
    logic [31:0] dat4 = 32'h0;
    logic        req4, burst4, we4, ierr4, busy4;
    logic [31:0] adr4, wradr4, wrdat4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mor1kx_icache_refill_master #(
        .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)
    ) u_dut5 (
        .clk(clk), .rst(rst),
        .refill_req_i(refill_req5), .refill_adr_i(refill_adr5),
        .ibus_req_o(req5), .ibus_adr_o(adr5), .ibus_burst_o(burst5),
        .ibus_ack_i(ack5), .ibus_err_i(err5), .ibus_dat_i(dat5),
        .wradr_o(wradr5), .wrdat_o(wrdat5), .we_o(we5),
        .imem_err_o(ierr5), .busy_o(busy5)
    );

    mor1kx_icache_refill_master #(
        .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)
    ) u_dut4 (
        .clk(clk), .rst(rst),
        .refill_req_i(refill_req4), .refill_adr_i(refill_adr4),
        .ibus_req_o(req4), .ibus_adr_o(adr4), .ibus_burst_o(burst4),
        .ibus_ack_i(ack4), .ibus_err_i(err4), .ibus_dat_i(dat4),
        .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4),
        .imem_err_o(ierr4), .busy_o(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 8-beat burst with ack every cycle on the 32-byte instance.
    // Entered one cycle after the request was seen (state already BURST).
    task automatic run_burst5(input logic [31:0] blk, input int off, input string tag);
        logic [31:0] exp_adr;
        for (int i = 0; i < 8; i++) begin
            exp_adr = blk + 32'((off + 4 * i) % 32);
            ack5 = 1'b1;
            dat5 = $urandom;
            #1;
            chk({tag, " adr"},   adr5,   exp_adr);
            chk({tag, " req"},   32'(req5), 32'd1);
            chk({tag, " we"},    32'(we5),  32'd1);
            chk({tag, " wradr"}, wradr5, exp_adr);
            chk({tag, " wrdat"}, wrdat5, dat5);
            chk({tag, " burst"}, 32'(burst5), 32'(i != 7));
            tick();
        end
        ack5 = 1'b0;
        #1;
        chk({tag, " req after"},  32'(req5),  32'd0);
        chk({tag, " busy after"}, 32'(busy5), 32'd0);
        chk({tag, " we after"},   32'(we5),   32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst req",   32'(req5),   32'd0);
        chk("rst burst", 32'(burst5), 32'd0);
        chk("rst we",    32'(we5),    32'd0);
        chk("rst ierr",  32'(ierr5),  32'd0);
        chk("rst busy",  32'(busy5),  32'd0);
        chk("rst adr",   adr5,        32'h0);
        chk("rst busy4", 32'(busy4),  32'd0);
        rst = 1'b0;
        tick();

        // Test 1: 32-byte block from 0x1014, ack every cycle
        refill_req5 = 1'b1;
        refill_adr5 = 32'h0000_1016;
        #1;
        chk("t1 req latency", 32'(req5), 32'd0);
        tick();
        refill_req5 = 1'b0;
        refill_adr5 = 32'hFFFF_FFF0;   // must be ignored mid-burst
        run_burst5(32'h0000_1000, 20, "t1");
        tick();

        // Test 2: 16-byte block from 0x2008, ack on alternate cycles
        refill_req4 = 1'b1;
        refill_adr4 = 32'h0000_2008;
        tick();
        refill_req4 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ack4 = c[0];
            dat4 = 32'hB000_0000 + 32'(c);
            #1;
            chk("t2 adr",   adr4, 32'h0000_2000 + 32'((8 + 4 * (c / 2)) % 16));
            chk("t2 we",    32'(we4), 32'(c[0]));
            chk("t2 burst", 32'(burst4), 32'((c / 2) != 3));
            chk("t2 req",   32'(req4), 32'd1);
            if (c[0]) begin
                chk("t2 wradr", wradr4, 32'h0000_2000 + 32'((8 + 4 * (c / 2)) % 16));
            end else begin
                chk("t2 wrdat", wrdat4, dat4);
            end
            tick();
        end
        ack4 = 1'b0;
        #1;
        chk("t2 req after",  32'(req4),  32'd0);
        chk("t2 busy after", 32'(busy4), 32'd0);
        tick();

        // Test 3: error on 3rd beat with ack also high
        refill_req5 = 1'b1;
        refill_adr5 = 32'h0000_1000;
        tick();
        for (int i = 0; i < 2; i++) begin
            ack5 = 1'b1;
            #1;
            chk("t3 we pre", 32'(we5), 32'd1);
            chk("t3 ierr pre", 32'(ierr5), 32'd0);
            tick();
        end
        ack5 = 1'b1;
        err5 = 1'b1;
        #1;
        chk("t3 ierr", 32'(ierr5), 32'd1);
        chk("t3 we on err", 32'(we5), 32'd0);
        tick();
        ack5 = 1'b0;
        err5 = 1'b0;
        #1;
        chk("t3 req after err", 32'(req5), 32'd0);
        chk("t3 ierr one cycle", 32'(ierr5), 32'd0);
        chk("t3 busy errwait", 32'(busy5), 32'd1);
        tick();
        chk("t3 still errwait", 32'(busy5), 32'd1);
        chk("t3 req errwait", 32'(req5), 32'd0);
        refill_req5 = 1'b0;
        tick();
        chk("t3 idle busy", 32'(busy5), 32'd0);
        chk("t3 idle req", 32'(req5), 32'd0);
        tick();

        // Test 4: reset after two acks, then a clean restart
        refill_req5 = 1'b1;
        refill_adr5 = 32'h0000_1008;
        tick();
        refill_req5 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ack5 = 1'b1;
            tick();
        end
        ack5 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack5 = 1'b1;
        #1;
        chk("t4 req", 32'(req5), 32'd0);
        chk("t4 busy", 32'(busy5), 32'd0);
        chk("t4 we", 32'(we5), 32'd0);
        chk("t4 adr", adr5, 32'h0);
        ack5 = 1'b0;
        refill_req5 = 1'b1;
        refill_adr5 = 32'h0000_1018;
        tick();
        refill_req5 = 1'b0;
        run_burst5(32'h0000_1000, 24, "t4");
        tick();

        // Test 5: request held across two consecutive misses
        refill_req5 = 1'b1;
        refill_adr5 = 32'h0000_1000;
        tick();
        refill_adr5 = 32'h0000_3004;
        run_burst5(32'h0000_1000, 0, "t5a");
        tick();
        refill_req5 = 1'b0;
        #1;
        chk("t5 second req", 32'(req5), 32'd1);
        run_burst5(32'h0000_3000, 4, "t5b");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
